// File: rtl/decade_2of5_checker.sv
// Reader/checker for a 2-of-5 buffer-ring decade counter: decodes each code to a
// digit, flags illegal patterns and illegal steps, and counts error events.
module decade_2of5_checker #(
  parameter int ERR_CNT_W = 8,
  parameter bit CHECK_SEQ = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [4:0]           i_code,
  input  logic                 i_advance,
  input  logic                 i_clear,
  input  logic                 i_err_clr,
  output logic [3:0]           o_digit,
  output logic                 o_valid,
  output logic                 o_bad_code,
  output logic                 o_bad_seq,
  output logic [ERR_CNT_W-1:0] o_err_count
);

  localparam int SUM_W = ERR_CNT_W + 2;
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = {ERR_CNT_W{1'b1}};
  localparam logic [4:0] CODE_ZERO = 5'b00011;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_ADV  = 2'd1,
    PEND_CLR  = 2'd2
  } pend_e;

  function automatic logic is_two_hot(input logic [4:0] c);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 5; i++) begin
      n = n + {2'b00, c[i]};
    end
    return (n == 3'd2);
  endfunction

  function automatic logic [3:0] code_to_digit(input logic [4:0] c);
    logic [3:0] d;
    case (c)
      5'b10010: d = 4'd1;
      5'b10001: d = 4'd2;
      5'b01001: d = 4'd3;
      5'b11000: d = 4'd4;
      5'b10100: d = 4'd5;
      5'b01100: d = 4'd6;
      5'b01010: d = 4'd7;
      5'b00110: d = 4'd8;
      5'b00101: d = 4'd9;
      default:  d = 4'd0;
    endcase
    return d;
  endfunction

  function automatic logic [4:0] digit_to_code(input logic [3:0] d);
    logic [4:0] c;
    case (d)
      4'd1:    c = 5'b10010;
      4'd2:    c = 5'b10001;
      4'd3:    c = 5'b01001;
      4'd4:    c = 5'b11000;
      4'd5:    c = 5'b10100;
      4'd6:    c = 5'b01100;
      4'd7:    c = 5'b01010;
      4'd8:    c = 5'b00110;
      4'd9:    c = 5'b00101;
      default: c = CODE_ZERO;
    endcase
    return c;
  endfunction

  function automatic logic [4:0] succ_code(input logic [4:0] c);
    logic [3:0] d;
    d = code_to_digit(c);
    return digit_to_code((d == 4'd9) ? 4'd0 : d + 4'd1);
  endfunction

  logic                 last_adv_q, last_clr_q, first_q, valid_q;
  logic                 bad_code_q, bad_seq_q;
  logic [4:0]           code_q, exp_q, exp_d;
  logic [3:0]           digit_q, digit_d;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d, cnt_base_s;
  logic [SUM_W-1:0]     sum_s;
  logic [1:0]           incr_s;
  logic                 valid_s, adv_rise_s, clr_rise_s, seq_err_s, seq_evt_s, code_evt_s;
  logic                 bad_code_d, bad_seq_d;
  pend_e                pend_q, pend_d;

  // Next-state: pending-step checks, error events and saturating count.
  always_comb begin
    valid_s    = is_two_hot(i_code);
    adv_rise_s = i_advance & ~last_adv_q;
    clr_rise_s = i_clear & ~last_clr_q;
    seq_err_s  = 1'b0;
    pend_d     = PEND_NONE;
    exp_d      = exp_q;

    case (pend_q)
      PEND_ADV:  seq_err_s = (i_code != exp_q);
      PEND_CLR:  seq_err_s = (i_code != CODE_ZERO);
      PEND_NONE: seq_err_s = ~adv_rise_s & ~clr_rise_s & ~first_q & (i_code != code_q);
      default:   seq_err_s = 1'b0;
    endcase

    // The ring moves on this same edge, so the expected code is checked next cycle.
    if (clr_rise_s) begin
      pend_d = PEND_CLR;
    end else if (adv_rise_s && valid_s) begin
      pend_d = PEND_ADV;
      exp_d  = succ_code(i_code);
    end else begin
      pend_d = PEND_NONE;
    end

    seq_evt_s  = CHECK_SEQ ? seq_err_s : 1'b0;
    code_evt_s = ~valid_s & (valid_q | first_q);
    incr_s     = {1'b0, code_evt_s} + {1'b0, seq_evt_s};
    cnt_base_s = i_err_clr ? {ERR_CNT_W{1'b0}} : cnt_q;
    sum_s      = SUM_W'(cnt_base_s) + SUM_W'(incr_s);
    if (sum_s > SUM_W'(CNT_MAX)) begin
      cnt_d = CNT_MAX;
    end else begin
      cnt_d = sum_s[ERR_CNT_W-1:0];
    end

    bad_code_d = ~valid_s | (bad_code_q & ~i_err_clr);
    bad_seq_d  = seq_evt_s | (bad_seq_q & ~i_err_clr);
    digit_d    = valid_s ? code_to_digit(i_code) : digit_q;
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      last_adv_q <= 1'b0;
      last_clr_q <= 1'b0;
      first_q    <= 1'b1;
      valid_q    <= 1'b0;
      code_q     <= 5'd0;
      exp_q      <= 5'd0;
      digit_q    <= 4'd0;
      bad_code_q <= 1'b0;
      bad_seq_q  <= 1'b0;
      cnt_q      <= {ERR_CNT_W{1'b0}};
      pend_q     <= PEND_NONE;
    end else begin
      last_adv_q <= i_advance;
      last_clr_q <= i_clear;
      first_q    <= 1'b0;
      valid_q    <= valid_s;
      code_q     <= i_code;
      exp_q      <= exp_d;
      digit_q    <= digit_d;
      bad_code_q <= bad_code_d;
      bad_seq_q  <= bad_seq_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
    end
  end

  assign o_digit     = digit_q;
  assign o_valid     = valid_q;
  assign o_bad_code  = bad_code_q;
  assign o_bad_seq   = bad_seq_q;
  assign o_err_count = cnt_q;

endmodule

// File: tb/tb_decade_2of5_checker.sv
// Bench for decade_2of5_checker: directed scenarios plus a randomized ring with
// injected faults, checked every cycle against a digit-level behavioural model.
module tb_decade_2of5_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] code;
  logic       adv, clr, eclr;
  logic [3:0] digit, digit2;
  logic       valid, valid2, bcode, bcode2, bseq, bseq2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int n_checks = 0;
  int n_errors = 0;

  decade_2of5_checker #(.ERR_CNT_W(8), .CHECK_SEQ(1'b1)) dut (
    .i_clk(clk), .i_reset(rst), .i_code(code), .i_advance(adv), .i_clear(clr),
    .i_err_clr(eclr), .o_digit(digit), .o_valid(valid), .o_bad_code(bcode),
    .o_bad_seq(bseq), .o_err_count(cnt8));

  decade_2of5_checker #(.ERR_CNT_W(2), .CHECK_SEQ(1'b1)) dut2 (
    .i_clk(clk), .i_reset(rst), .i_code(code), .i_advance(adv), .i_clear(clr),
    .i_err_clr(eclr), .o_digit(digit2), .o_valid(valid2), .o_bad_code(bcode2),
    .o_bad_seq(bseq2), .o_err_count(cnt2));

  always #5 clk = ~clk;

  logic [4:0] codes [10] = '{5'b00011, 5'b10010, 5'b10001, 5'b01001, 5'b11000,
                             5'b10100, 5'b01100, 5'b01010, 5'b00110, 5'b00101};

  // Model state, expressed as digits and an unbounded event total.
  int   m_digit, m_total, m_pend, m_exp_digit;
  bit   m_valid, m_bad_code, m_bad_seq, m_first, m_last_adv, m_last_clr;
  logic [4:0] m_code;

  function automatic int digit_of(input logic [4:0] c);
    for (int i = 0; i < 10; i++) if (codes[i] == c) return i;
    return -1;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_digit = 0; m_total = 0; m_pend = 0; m_exp_digit = 0;
    m_valid = 0; m_bad_code = 0; m_bad_seq = 0; m_first = 1;
    m_last_adv = 0; m_last_clr = 0; m_code = 5'd0;
  endtask

  task automatic model_step();
    int  d, ev;
    bit  ok, adv_r, clr_r, seq, cevt;
    d     = digit_of(code);
    ok    = (d >= 0);
    adv_r = adv && !m_last_adv;
    clr_r = clr && !m_last_clr;
    if (m_pend == 1)      seq = (code != codes[m_exp_digit]);
    else if (m_pend == 2) seq = (code != codes[0]);
    else                  seq = !adv_r && !clr_r && !m_first && (code != m_code);
    cevt = !ok && (m_valid || m_first);
    ev   = int'(cevt) + int'(seq);
    m_total    = eclr ? ev : m_total + ev;
    m_bad_code = !ok || (m_bad_code && !eclr);
    m_bad_seq  = seq || (m_bad_seq && !eclr);
    if (clr_r) m_pend = 2;
    else if (adv_r && ok) begin m_pend = 1; m_exp_digit = (d + 1) % 10; end
    else m_pend = 0;
    if (ok) m_digit = d;
    m_valid = ok; m_code = code; m_last_adv = adv; m_last_clr = clr; m_first = 0;
  endtask

  task automatic compare_all();
    check("digit", int'(digit), m_digit);
    check("valid", int'(valid), int'(m_valid));
    check("bad_code", int'(bcode), int'(m_bad_code));
    check("bad_seq", int'(bseq), int'(m_bad_seq));
    check("count_w8", int'(cnt8), (m_total > 255) ? 255 : m_total);
    check("count_w2", int'(cnt2), (m_total > 3) ? 3 : m_total);
  endtask

  // One clock: inputs applied at negedge, model advanced, outputs compared next negedge.
  task automatic cycle(input bit a, input bit c, input logic [4:0] cd, input bit e);
    adv = a; clr = c; code = cd; eclr = e;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; adv = 1'b0; clr = 1'b0; eclr = 1'b0;
    #1;
    check("rst_digit", int'(digit), 0);
    check("rst_flags", int'({valid, bcode, bseq}), 0);
    check("rst_count", int'(cnt8) + int'(cnt2), 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int r, ring, pa, pc;
    bit a, c, e;
    logic [4:0] cd;
    rst = 1'b1; code = 5'b00011; adv = 1'b0; clr = 1'b0; eclr = 1'b0;
    @(negedge clk);

    // Clear then ten advances: 0,1..9,0 with no errors.
    do_reset();
    cycle(0, 1, 5'b00011, 0);
    cycle(0, 0, 5'b00011, 0);
    for (int i = 1; i <= 10; i++) begin
      cycle(1, 0, codes[i - 1], 0);
      cycle(0, 0, codes[i % 10], 0);
      check("walk_digit", int'(digit), i % 10);
    end
    check("walk_count", int'(cnt8), 0);
    check("walk_flags", int'({bcode, bseq}), 0);

    // Advance at "0" but the ring shows "2".
    cycle(1, 0, 5'b00011, 0);
    cycle(0, 0, 5'b10001, 0);
    cycle(0, 0, 5'b10001, 0);
    cycle(0, 0, 5'b10001, 0);
    check("badstep_seq", int'(bseq), 1);
    check("badstep_count", int'(cnt8), 1);

    // Spurious change without any strobe.
    do_reset();
    cycle(0, 0, 5'b01100, 0);
    cycle(0, 0, 5'b01100, 0);
    cycle(0, 0, 5'b01010, 0);
    check("spurious_seq", int'(bseq), 1);
    check("spurious_count", int'(cnt8), 1);

    // Invalid pattern held three cycles.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(0, 0, 5'b10110, 0);
    check("inv_valid", int'(valid), 0);
    check("inv_digit", int'(digit), 0);
    check("inv_code", int'(bcode), 1);
    check("inv_count", int'(cnt8), 1);

    // Clear that does not take, then err_clr racing a new error.
    do_reset();
    cycle(0, 0, 5'b01010, 0);
    cycle(0, 1, 5'b01010, 0);
    cycle(0, 0, 5'b01010, 0);
    check("badclr_seq", int'(bseq), 1);
    cycle(0, 0, 5'b00110, 1);
    check("eclr_race_seq", int'(bseq), 1);
    check("eclr_race_count", int'(cnt8), 1);
    cycle(0, 0, 5'b00110, 1);
    check("eclr_quiet", int'({bseq, cnt8}), 0);

    // Five events: narrow counter saturates; then reset while a step is pending.
    do_reset();
    cycle(0, 0, 5'b01100, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, (i % 2 == 0) ? 5'b01010 : 5'b01100, 0);
    check("sat_w2", int'(cnt2), 3);
    check("sat_w8", int'(cnt8), 5);
    cycle(1, 0, 5'b01100, 0);
    do_reset();
    cycle(0, 0, 5'b01010, 0);
    check("post_rst", int'({bseq, bcode, cnt8}), 0);

    // Randomized ring with occasional faults, strobe glitches and error clears.
    do_reset();
    ring = 0; pa = 0; pc = 0;
    for (int i = 0; i < 2000; i++) begin
      r = int'($urandom_range(0, 999));
      if (r < 2) begin
        do_reset();
        pa = 0; pc = 0;
      end else begin
        a = (r < 300) ? ~adv : adv;
        c = (r >= 300 && r < 340) ? ~clr : clr;
        e = ($urandom_range(0, 99) < 3);
        if ($urandom_range(0, 99) < 4) cd = 5'($urandom_range(0, 31));
        else cd = codes[ring];
        cycle(a, c, cd, e);
        if (c && !pc) ring = 0;
        else if (a && !pa) ring = (ring + 1) % 10;
        if ($urandom_range(0, 99) < 2) ring = int'($urandom_range(0, 9));
        pa = int'(a); pc = int'(c);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
